mux_serializer: RTL and testbench
=================================

MUX_SERIALIZER -- requirements
Module: mux_serializer

Interface
REQ-001 SHALL have parameter: WIDTH, 4, parallel word width; legal values 2, 4, 8.
REQ-002 SHALL have derived constant: SW, clog2(WIDTH), width of the select index.
REQ-003 SHALL have port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port: in_valid  input  1  upstream offers in_data.
REQ-006 SHALL have port: in_ready  output  1  block accepts a word this cycle.
REQ-007 SHALL have port: in_data  input  WIDTH  parallel word to serialize.
REQ-008 SHALL have port: out_bit  output  1  current serial bit, equal to held_word[sel].
REQ-009 SHALL have port: out_valid  output  1  out_bit is valid.
REQ-010 SHALL have port: out_ready  input  1  downstream consumes out_bit this cycle.
REQ-011 SHALL have port: out_last  output  1  out_bit is the MSB (sel == WIDTH-1) of the word.
REQ-012 SHALL have port: sel  output  SW  current mux select index, for driving a downstream select line.

Function
REQ-013 SHALL implement two states: IDLE and SHIFT.
REQ-014 SHALL make an input transfer occur on a rising edge where in_valid && in_ready.
REQ-015 SHALL make an output transfer occur on a rising edge where out_valid && out_ready.
REQ-016 SHALL in IDLE drive in_ready=1, out_valid=0, out_last=0, sel=0 and out_bit=0.
REQ-017 SHALL on an input transfer in IDLE latch in_data into held_word, set sel=0 and go to SHIFT, so out_valid=1 the next cycle (latency 1 clock).
REQ-018 SHALL in SHIFT drive out_valid=1 and out_bit=held_word[sel], serializing LSB first.
REQ-019 SHALL in SHIFT on an output transfer with sel < WIDTH-1 increment sel by 1; with out_ready=0, hold sel, held_word and out_bit unchanged.
REQ-020 SHALL in SHIFT drive in_ready = out_last && out_ready; otherwise in_ready=0.
REQ-021 SHALL on an output transfer with out_last=1: if an input transfer occurs on the same edge, latch the new word, set sel=0 and stay in SHIFT (zero-gap back-to-back); otherwise return to IDLE.
REQ-022 SHALL ignore in_data and in_valid while in_ready=0.
REQ-023 SHALL never let sel exceed WIDTH-1 and never wrap it past 0 except through REQ-021.
REQ-024 SHALL leave held_word unchanged while in SHIFT except on the REQ-021 reload.

Reset
REQ-025 SHALL on rst_n=0 immediately, without waiting for clk, force state=IDLE, sel=0, held_word=0, out_valid=0, out_last=0 and out_bit=0.
REQ-026 SHALL on reset mid-word discard the partial word with no further out_valid pulse for it.
REQ-027 SHALL after rst_n rises make the first input transfer possible on the first following clk edge.

Structure
REQ-028 SHALL place the state encoding (IDLE=1'b0, SHIFT=1'b1) and the legal-WIDTH check in a shared package mux_serializer_pkg.
REQ-029 SHALL contain one sub-module sel_counter: SW-bit up-counter with enable, synchronous load-to-zero and terminal-count flag, using the same async active-low reset.

Verification
REQ-030 SHALL verify: WIDTH=4, in_data=4'b1011 accepted, out_ready=1 -> out_bit 1,1,0,1 on four consecutive cycles, sel 0..3, out_last only on cycle 4, then IDLE.
REQ-031 SHALL verify: 4'b0110 then 4'b1001 offered back-to-back with in_valid held high -> eight contiguous out_valid cycles giving 0,1,1,0,1,0,0,1 with no gap, in_ready high only on the edge of each out_last.
REQ-032 SHALL verify: out_ready=0 for 3 cycles at sel=2 of 4'b0100 -> sel, out_bit=1 and out_valid held stable, resume at sel=3 with out_bit=0.
REQ-033 SHALL verify: rst_n asserted low mid-clock at sel=1 -> outputs reach reset values before the next clk edge, and the next word 4'b1111 serializes from sel=0.
REQ-034 SHALL verify: in_valid toggled during SHIFT with changing in_data -> held_word unaffected, output sequence matches the originally accepted word.
REQ-035 SHALL verify: WIDTH=2 and WIDTH=8 with 2'b10 and 8'hA5 -> LSB-first streams 0,1 and 1,0,1,0,0,1,0,1 respectively.

Source files
------------

// File: rtl/mux_serializer_pkg.sv
// Shared types and elaboration helpers for the mux serializer.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
//
// Contents:
//   state_t         - serializer control state (IDLE = 0, SHIFT = 1)
//   width_is_legal  - true for the supported parallel word widths
package mux_serializer_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Only power-of-two widths up to 8 are supported, so the select
    // index always covers the whole word without an out-of-range code.
    function automatic bit width_is_legal(input int w);
        return (w == 2) || (w == 4) || (w == 8);
    endfunction

endpackage

// File: rtl/mux_serializer_sel_counter.sv
// Select-index up-counter with enable, sync clear and terminal-count flag.
// Latency: count updates one clk after en/clr; tc is combinational on cnt.
// Backpressure: holds its value while en is low; saturates at N-1.
//
// Ports:
//   clk, rst_n - clock, async active-low reset (cnt -> 0)
//   clr        - synchronous load-to-zero, wins over en
//   en         - advance by one when not at terminal count
//   cnt        - current count, SW bits
//   tc         - cnt == N-1
module sel_counter #(
    parameter int N  = 4,
    parameter int SW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          en,
    output logic [SW-1:0] cnt,
    output logic          tc
);

    assign tc = (cnt == SW'(N - 1));

    // Gating the increment with !tc keeps the count inside 0..N-1 even if
    // a caller enables it at the terminal value; only clr wraps to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && !tc) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mux_serializer.sv
// Parallel-to-serial mux: latches a WIDTH-bit word, emits it LSB first.
// Latency: 1 clk from input transfer to first out_valid; zero-gap reload.
// Backpressure: out_ready=0 freezes sel/out_bit; in_ready only at last bit.
//
// Ports:
//   clk, rst_n                    - clock, async active-low reset
//   in_valid/in_ready/in_data     - parallel word handshake
//   out_valid/out_ready/out_bit   - serial bit handshake
//   out_last                      - current bit is the word MSB
//   sel                           - current mux select index
module mux_serializer
    import mux_serializer_pkg::*;
#(
    parameter  int WIDTH = 4,
    localparam int SW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_bit,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic [SW-1:0]    sel
);

    if (!width_is_legal(WIDTH)) begin : g_width_check
        $error("mux_serializer: WIDTH must be 2, 4 or 8");
    end

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] held_q;
    logic [SW-1:0]    sel_cnt;
    logic             sel_tc;
    logic             in_fire;
    logic             out_fire;
    logic             word_done;

    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;
    assign word_done = out_fire && out_last;

    // Clearing on word_done as well as on a new load means sel already reads
    // zero whenever the block sits in IDLE.
    sel_counter #(
        .N  (WIDTH),
        .SW (SW)
    ) u_sel_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (in_fire || word_done),
        .en    (out_fire),
        .cnt   (sel_cnt),
        .tc    (sel_tc)
    );

    assign sel = sel_cnt;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Held word: only written on an accepted input word, so anything on
    // in_data while in_ready is low never reaches the output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            held_q <= '0;
        end else if (in_fire) begin
            held_q <= in_data;
        end
    end

    // Next-state logic. In SHIFT an input transfer can only happen together
    // with the last-bit output transfer, which is the back-to-back reload.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (in_fire) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (word_done && !in_fire) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic. All outputs decode from registered state, so an async
    // reset takes them to their idle values without waiting for clk.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        out_bit   = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
            end
            SHIFT: begin
                out_valid = 1'b1;
                out_last  = sel_tc;
                out_bit   = held_q[sel_cnt];
                in_ready  = sel_tc && out_ready;
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_mux_serializer.sv
// Self-checking bench for mux_serializer at WIDTH = 4, 2 and 8.
// Expected serial bits are queued when a word is offered and compared as
// the corresponding output transfers occur.
module tb_mux_serializer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // WIDTH = 4 instance
    logic       iv4, ir4, ob4, ov4, or4, ol4;
    logic [3:0] id4;
    logic [1:0] sel4;
    // WIDTH = 2 instance
    logic       iv2, ir2, ob2, ov2, or2, ol2;
    logic [1:0] id2;
    logic [0:0] sel2;
    // WIDTH = 8 instance
    logic       iv8, ir8, ob8, ov8, or8, ol8;
    logic [7:0] id8;
    logic [2:0] sel8;

    mux_serializer #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .in_data(id4),
        .out_bit(ob4), .out_valid(ov4), .out_ready(or4), .out_last(ol4), .sel(sel4)
    );
    mux_serializer #(.WIDTH(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2), .in_data(id2),
        .out_bit(ob2), .out_valid(ov2), .out_ready(or2), .out_last(ol2), .sel(sel2)
    );
    mux_serializer #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .in_data(id8),
        .out_bit(ob8), .out_valid(ov8), .out_ready(or8), .out_last(ol8), .sel(sel8)
    );

    typedef struct {
        logic b;
        int   s;
        logic l;
    } exp_t;

    exp_t q4[$];
    exp_t q2[$];
    exp_t q8[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Queue the LSB-first bit stream a w-bit word should produce.
    task automatic push(input int w, input logic [7:0] d);
        for (int i = 0; i < w; i++) begin
            exp_t e;
            e.b = d[i];
            e.s = i;
            e.l = (i == w - 1);
            case (w)
                2:       q2.push_back(e);
                4:       q4.push_back(e);
                default: q8.push_back(e);
            endcase
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((q4.size() != 0 || q2.size() != 0 || q8.size() != 0) && n < 50) begin
            tick();
            n++;
        end
        chk("drain_timeout", 32'(n < 50), 1);
    endtask

    // Output monitors: sample at negedge, a transfer completes on the next posedge.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && ov4 && or4) begin
            if (q4.size() == 0) begin
                chk("w4_unexpected_out", 32'(ov4), 0);
            end else begin
                e = q4.pop_front();
                chk("w4_bit", 32'(ob4), 32'(e.b));
                chk("w4_sel", 32'(sel4), e.s);
                chk("w4_last", 32'(ol4), 32'(e.l));
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && ov2 && or2) begin
            if (q2.size() == 0) begin
                chk("w2_unexpected_out", 32'(ov2), 0);
            end else begin
                e = q2.pop_front();
                chk("w2_bit", 32'(ob2), 32'(e.b));
                chk("w2_sel", 32'(sel2), e.s);
                chk("w2_last", 32'(ol2), 32'(e.l));
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && ov8 && or8) begin
            if (q8.size() == 0) begin
                chk("w8_unexpected_out", 32'(ov8), 0);
            end else begin
                e = q8.pop_front();
                chk("w8_bit", 32'(ob8), 32'(e.b));
                chk("w8_sel", 32'(sel8), e.s);
                chk("w8_last", 32'(ol8), 32'(e.l));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        iv4 = 1'b0; id4 = '0; or4 = 1'b1;
        iv2 = 1'b0; id2 = '0; or2 = 1'b1;
        iv8 = 1'b0; id8 = '0; or8 = 1'b1;

        // Reset state
        #2;
        chk("rst_in_ready", 32'(ir4), 1);
        chk("rst_out_valid", 32'(ov4), 0);
        chk("rst_out_last", 32'(ol4), 0);
        chk("rst_sel", 32'(sel4), 0);
        chk("rst_out_bit", 32'(ob4), 0);
        chk("rst_valid_w2", 32'(ov2), 0);
        chk("rst_valid_w8", 32'(ov8), 0);
        tick();
        rst_n = 1'b1;

        // Single word 1011, accepted on the first edge after reset release
        iv4 = 1'b1; id4 = 4'b1011; push(4, 8'b1011);
        tick();
        chk("t1_accept", 32'(ov4), 1);
        iv4 = 1'b0; id4 = '0;
        wait_drain();
        chk("t1_idle_valid", 32'(ov4), 0);
        chk("t1_idle_ready", 32'(ir4), 1);
        chk("t1_idle_sel", 32'(sel4), 0);

        // Back-to-back 0110 then 1001 with in_valid held high
        iv4 = 1'b1; id4 = 4'b0110; push(4, 8'b0110);
        tick();
        id4 = 4'b1001; push(4, 8'b1001);
        for (int k = 0; k < 4; k++) begin
            chk("t2a_valid", 32'(ov4), 1);
            chk("t2a_in_ready", 32'(ir4), 32'(k == 3));
            tick();
        end
        iv4 = 1'b0; id4 = '0;
        for (int k = 0; k < 4; k++) begin
            chk("t2b_valid", 32'(ov4), 1);
            chk("t2b_in_ready", 32'(ir4), 32'(k == 3));
            tick();
        end
        chk("t2_idle", 32'(ov4), 0);
        chk("t2_queue", 32'(q4.size()), 0);

        // Stall at sel=2 of 0100 for three cycles
        iv4 = 1'b1; id4 = 4'b0100; push(4, 8'b0100);
        tick();
        iv4 = 1'b0;
        tick();
        tick();
        or4 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("t3_hold_sel", 32'(sel4), 2);
            chk("t3_hold_bit", 32'(ob4), 1);
            chk("t3_hold_valid", 32'(ov4), 1);
            chk("t3_hold_in_ready", 32'(ir4), 0);
            tick();
        end
        or4 = 1'b1;
        tick();
        chk("t3_resume_sel", 32'(sel4), 3);
        chk("t3_resume_bit", 32'(ob4), 0);
        wait_drain();

        // Asynchronous reset mid-word at sel=1
        iv4 = 1'b1; id4 = 4'b0101; push(4, 8'b0101);
        tick();
        iv4 = 1'b0;
        tick();
        chk("t4_pre_sel", 32'(sel4), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t4_async_valid", 32'(ov4), 0);
        chk("t4_async_sel", 32'(sel4), 0);
        chk("t4_async_bit", 32'(ob4), 0);
        chk("t4_async_last", 32'(ol4), 0);
        chk("t4_async_in_ready", 32'(ir4), 1);
        q4.delete();
        tick();
        chk("t4_in_reset_valid", 32'(ov4), 0);
        rst_n = 1'b1;
        iv4 = 1'b1; id4 = 4'b1111; push(4, 8'b1111);
        tick();
        chk("t4_accept", 32'(ov4), 1);
        iv4 = 1'b0; id4 = '0;
        wait_drain();

        // in_valid/in_data churn while shifting 1100
        iv4 = 1'b1; id4 = 4'b1100; push(4, 8'b1100);
        tick();
        for (int k = 0; k < 3; k++) begin
            iv4 = (k % 2 == 0);
            id4 = 4'($urandom);
            chk("t5_in_ready", 32'(ir4), 0);
            tick();
        end
        iv4 = 1'b0;
        wait_drain();
        chk("t5_idle", 32'(ov4), 0);

        // WIDTH=2 with 10 and WIDTH=8 with A5, run together
        iv2 = 1'b1; id2 = 2'b10; push(2, 8'b10);
        iv8 = 1'b1; id8 = 8'hA5; push(8, 8'hA5);
        tick();
        iv2 = 1'b0; iv8 = 1'b0;
        wait_drain();
        tick();
        chk("t6_idle_w2", 32'(ov2), 0);
        chk("t6_idle_w8", 32'(ov8), 0);

        chk("q_left", 32'(q4.size() + q2.size() + q8.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
